// File: rtl/not_gate.sv
// -----------------------------------------------------------------------------
// not_gate
//
// Pipelined bitwise inverter with valid/ready flow control on both sides.
// Every accepted word is transformed once, on entry, into in_data ^ inv_mask
// and then carried unchanged through STAGES register stages to the output.
// An all-ones mask gives a pure NOT; a zero mask is a plain registered pipe.
// A free-running counter tracks how many words have been delivered.
//
// Parameters
//   WIDTH   data / mask width in bits (>= 1)
//   STAGES  number of pipeline register stages (>= 1), equals the latency
//   CNT_W   width of the delivered-word counter
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         asynchronous, active-high reset
//   in_data     input word
//   inv_mask    per-bit invert enable, sampled together with in_data
//   in_valid    producer has a word
//   in_ready    block can take a word this cycle
//   out_data    result word (from the last stage)
//   out_valid   result present
//   out_ready   consumer takes the result this cycle
//   xfer_count  number of output transfers since reset, wraps
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid && ready are both high. A source holding valid keeps its word stable
// until that edge. ready may depend combinationally on the downstream ready
// (in_ready depends on out_ready), but valid never depends on ready.
// -----------------------------------------------------------------------------
module not_gate #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] inv_mask,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] xfer_count
);

    // Per-stage data word and valid bit.
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [STAGES-1:0] valid_q;

    // take[i]: stage i may load a new value (word or bubble) on this edge.
    // That is true when stage i is empty or its content moves on, which
    // unrolls to: out_ready is high, or some stage from i to the end is
    // empty. Computing it this way avoids a bit-to-bit chain inside one
    // vector while giving exactly the same combinational ready path.
    logic [STAGES-1:0] take;

    always_comb begin
        logic full_from;
        full_from = 1'b1;
        take      = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            full_from = full_from & valid_q[i];
            take[i]   = out_ready | ~full_from;
        end
    end

    assign in_ready = take[0];

    // Stage 0: the result is computed here, once, so later mask changes do
    // not touch words already in flight. Data only loads with a real word;
    // a bubble just clears the valid bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q[0] <= 1'b0;
            data_q[0]  <= '0;
        end else if (take[0]) begin
            valid_q[0] <= in_valid;
            if (in_valid) begin
                data_q[0] <= in_data ^ inv_mask;
            end
        end
    end

    // Stages 1..STAGES-1: move forward whenever allowed. A stalled stage
    // keeps both its data and valid bit, so nothing is dropped or repeated.
    for (genvar g = 1; g < STAGES; g++) begin : g_stage
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q[g] <= 1'b0;
                data_q[g]  <= '0;
            end else if (take[g]) begin
                valid_q[g] <= valid_q[g-1];
                if (valid_q[g-1]) begin
                    data_q[g] <= data_q[g-1];
                end
            end
        end
    end

    assign out_data  = data_q[STAGES-1];
    assign out_valid = valid_q[STAGES-1];

    // Delivered-word counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_count <= '0;
        end else if (out_valid && out_ready) begin
            xfer_count <= xfer_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_not_gate.sv
module tb_not_gate;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;
  localparam int CNT_W  = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] inv_mask;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] xfer_count;

  not_gate #(
    .WIDTH (WIDTH),
    .STAGES(STAGES),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .inv_mask  (inv_mask),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .xfer_count(xfer_count)
  );

  // ---------------------------------------------------------------- clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- checker
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  logic [WIDTH-1:0] exp_q[$];
  int               exp_count = 0;
  logic             hold_pending = 1'b0;
  logic [WIDTH-1:0] hold_data;

  // Inputs are stable from posedge+1 to the next posedge, so at the falling
  // edge we know exactly which handshakes the next rising edge will perform.
  always @(negedge clk) begin
    logic [WIDTH-1:0] w;
    if (!rst) begin
      check("xfer_count", 32'(xfer_count), 32'(exp_count % (1 << CNT_W)));
      if (hold_pending && out_valid) check("hold_data", 32'(out_data), 32'(hold_data));
      hold_pending = out_valid && !out_ready;
      hold_data    = out_data;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          w = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(w));
        end
        exp_count++;
      end
      if (in_valid && in_ready) exp_q.push_back(in_data ^ inv_mask);
    end else begin
      hold_pending = 1'b0;
    end
  end

  // ---------------------------------------------------------------- drivers
  // All driver tasks are entered and left at posedge+1.
  task automatic send(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] m);
    logic acc;
    int   n;
    in_data  = d;
    inv_mask = m;
    in_valid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    check("send_accepted", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [WIDTH-1:0] bp_words [4];
  logic [CNT_W-1:0] base_cnt;
  int               idx;
  logic             acc;

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    inv_mask  = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Reset state, checked while reset is held.
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_xfer_count", 32'(xfer_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Pure NOT with latency check on the first word.
    in_data  = 8'h00;
    inv_mask = 8'hFF;
    in_valid = 1'b1;
    @(negedge clk);
    check("lat_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("lat_early_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_data", 32'(out_data), 32'h0FF);
    send(8'hA5, 8'hFF);
    send(8'hFF, 8'hFF);
    drain();
    check("not_count", 32'(xfer_count), 32'd3);

    // Partial and zero masks.
    send(8'h3C, 8'h0F);
    send(8'h3C, 8'h00);
    drain();

    // Back-pressure: only two words fit, output holds the first result.
    bp_words[0] = 8'h11;
    bp_words[1] = 8'h22;
    bp_words[2] = 8'h33;
    bp_words[3] = 8'h44;
    out_ready = 1'b0;
    inv_mask  = 8'hFF;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_data  = bp_words[idx];
      in_valid = 1'b1;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    check("bp_accepted", 32'(idx), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_out_data", 32'(out_data), 32'h0EE);
    out_ready = 1'b1;
    while (idx < 4) begin
      in_data  = bp_words[idx];
      in_valid = 1'b1;
      @(negedge clk);
      acc = in_ready;
      check("bp_stream_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("bp_tail_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    drain();

    // Simultaneous accept and deliver on a full pipeline.
    out_ready = 1'b0;
    send(8'h01, 8'hFF);
    send(8'h02, 8'hFF);
    base_cnt  = xfer_count;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_data  = 8'($urandom_range(0, 255));
      inv_mask = 8'($urandom_range(0, 255));
      in_valid = 1'b1;
      @(negedge clk);
      check("sim_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    drain();
    check("sim_delivered", 32'(CNT_W'(xfer_count - base_cnt)), 32'd12);

    // Random valid/ready traffic, bubbles collapse under stalls.
    for (int c = 0; c < 300; c++) begin
      in_data   = 8'($urandom_range(0, 255));
      inv_mask  = 8'($urandom_range(0, 255));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    drain();

    // Reset mid-stream discards in-flight words at once.
    out_ready = 1'b0;
    send(8'h5A, 8'hFF);
    send(8'h6B, 8'hFF);
    @(posedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    exp_q.delete();
    exp_count = 0;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_xfer_count", 32'(xfer_count), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    idle(2);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Counter wrap: 17 transfers on a 4-bit counter.
    idx = 0;
    while (idx < 17) begin
      in_data  = 8'(idx);
      inv_mask = 8'hFF;
      in_valid = 1'b1;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    drain();
    check("wrap_count", 32'(xfer_count), 32'd1);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/not_gate.md
# not_gate

Parameterised, pipelined bitwise inverter with valid/ready flow control on both sides. Each accepted word leaves as `in_data ^ inv_mask`; with an all-ones mask this is a pure NOT. It sits between a streaming producer and consumer wherever a registered, back-pressurable inversion stage is needed. It also keeps a count of delivered words.

## Interface
- `WIDTH`, default 8: data and mask width in bits (≥1).
- `STAGES`, default 2: pipeline register stages (≥1); sets the latency.
- `CNT_W`, default 16: width of the transfer counter.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: reset; asynchronous and active-high.
- `in_data`  in  WIDTH: input word.
- `inv_mask`  in  WIDTH: per-bit invert enable, sampled together with `in_data`.
- `in_valid`  in  1: input word present.
- `in_ready`  out  1: block accepts input this cycle.
- `out_data`  out  WIDTH: result word.
- `out_valid`  out  1: result present.
- `out_ready`  in  1: consumer accepts the result.
- `xfer_count`  out  CNT_W: number of output transfers since reset.

## Operation
- Input handshake: a word is accepted on a rising edge where `in_valid && in_ready`.
- At acceptance, stage 0 loads `in_data ^ inv_mask` and sets its valid bit.
- The result is computed once, at entry. Later `inv_mask` changes do not affect words already in flight.
- The pipeline is a chain of `STAGES` registers, each holding a data word and a valid bit. `out_data`/`out_valid` come from the last stage.
- Stage i advances when stage i+1 is empty or advancing. The last stage advances when `out_ready` is high.
- `in_ready = !valid[0] || advance[0]`. This is a combinational ready chain from `out_ready` back to `in_ready`, and gives full throughput with no bubbles.
- Output handshake: a word is delivered on an edge where `out_valid && out_ready`.
- A stalled stage holds its data and valid bit unchanged. No word is dropped or duplicated.
- `out_data` is stable while `out_valid && !out_ready`.
- `xfer_count` increments by 1 on each output transfer and wraps modulo 2^CNT_W.
- Words leave in acceptance order.

## Timing
- Reset (async assert, synchronous-to-`clk` release):
  - all valid bits 0, all data registers 0;
  - `out_valid`=0, `out_data`=0, `xfer_count`=0;
  - `in_ready`=1 during and after reset.
- A reset asserted mid-stream discards every in-flight word immediately.
- Latency: a word accepted at edge k is presented on `out_data` with `out_valid`=1 after edge k+STAGES−1 (visible from that edge), assuming no stall.
  - With `STAGES`=1 it appears right after the accepting edge.
- Throughput: one word per cycle while `out_ready`=1.
- Simultaneous events:
  - With all stages full, `out_ready`=1 and `in_valid`=1: accept and deliver on the same edge; occupancy is unchanged.
  - With all stages full and `out_ready`=0: `in_ready`=0.
- Boundaries:
  - `inv_mask`=0 passes data through unchanged.
  - Count wrap: at all-ones, one more transfer gives 0.
  - `in_valid` toggling freely creates bubbles that collapse when the output stalls.

## Test plan
- Reset: drive `rst`=1 mid-stream with words in flight → `out_valid`=0, `out_data`=0, `xfer_count`=0 immediately; `in_ready`=1.
- Pure NOT, WIDTH=8, STAGES=2: send 0x00, 0xA5, 0xFF with mask 0xFF and `out_ready`=1 → outputs 0xFF, 0x5A, 0x00; the first is valid one edge after acceptance; `xfer_count`=3.
- Partial mask: `in_data`=0x3C, mask=0x0F → `out_data`=0x33; mask=0x00 → 0x3C.
- Back-pressure: hold `out_ready`=0 and stream 4 words → `in_ready` falls after 2 accepted words and `out_data` holds the first result. Then release `out_ready` → all 4 words emerge in order, one per cycle, none lost.
- Simultaneous: full pipeline with `out_ready`=1 and `in_valid`=1 every cycle for 10 cycles → `in_ready` stays 1 and 10 words are delivered.
- Counter wrap, CNT_W=4: 17 transfers → `xfer_count`=1.
